// File: rtl/reg_scoreboard_pkg.sv
// Shared defaults and width helpers for the register scoreboard.
package reg_scoreboard_pkg;

    localparam int NUM_REGS_DEF = 16;
    localparam int NUM_WB_DEF   = 2;
    localparam int CNT_W_DEF    = 2;
    localparam int CC_REGS_DEF  = 8;

    // Index width for n registers; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width able to hold a count of 0..n.
    function automatic int cnt_w_for(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/scoreboard_counter.sv
// Pending-write counter for one architectural register, with writeback hit
// counting, same-cycle bypass and underflow detection.
module scoreboard_counter
    import reg_scoreboard_pkg::*;
#(
    parameter int NUM_WB = NUM_WB_DEF,
    parameter int IDX_W  = 4,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int REG_ID = 0
) (
    input  logic                    I_CLOCK,
    input  logic                    I_RESET,
    input  logic                    I_LOCK,
    input  logic [NUM_WB-1:0]       I_WbEnable,
    input  logic [NUM_WB*IDX_W-1:0] I_WbRegIdx,
    input  logic                    inc,
    output logic                    pend_eff,
    output logic                    full,
    output logic                    pending,
    output logic                    nz_nxt,
    output logic                    underflow
);

    localparam int HIT_W = cnt_w_for(NUM_WB);
    localparam int SW    = (CNT_W > HIT_W) ? CNT_W : HIT_W;
    localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [HIT_W-1:0] hits;
    logic [SW-1:0]    cnt_x, hits_x, drained;

    always_comb begin
        hits = '0;
        for (int p = 0; p < NUM_WB; p++)
            if (I_WbEnable[p] && I_WbRegIdx[p*IDX_W +: IDX_W] == IDX_W'(REG_ID))
                hits = hits + HIT_W'(1);
    end

    // Compare in a common width so a hit count wider than the counter is exact.
    always_comb begin
        cnt_x     = SW'(cnt);
        hits_x    = SW'(hits);
        pend_eff  = cnt_x > hits_x;
        underflow = hits_x > cnt_x;
        drained   = underflow ? '0 : cnt_x - hits_x;
        cnt_nxt   = CNT_W'(drained) + CNT_W'(inc);
        nz_nxt    = cnt_nxt != '0;
        full      = (cnt == CMAX) && (hits == '0);
    end

    always_ff @(posedge I_CLOCK) begin
        if (I_RESET) begin
            cnt     <= '0;
            pending <= 1'b0;
        end else if (I_LOCK) begin
            cnt     <= cnt_nxt;
            pending <= nz_nxt;
        end
    end

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard: tracks outstanding writes per register and stalls
// issue on RAW, condition-code and counter-full hazards.
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter  int NUM_REGS = NUM_REGS_DEF,
    parameter  int NUM_WB   = NUM_WB_DEF,
    parameter  int CNT_W    = CNT_W_DEF,
    parameter  int CC_REGS  = CC_REGS_DEF,
    localparam int IDX_W    = idx_w(NUM_REGS)
) (
    input  logic                    I_CLOCK,
    input  logic                    I_RESET,
    input  logic                    I_LOCK,
    input  logic                    I_IssueValid,
    input  logic [IDX_W-1:0]        I_Src1Idx,
    input  logic [IDX_W-1:0]        I_Src2Idx,
    input  logic [IDX_W-1:0]        I_DestIdx,
    input  logic                    I_Src1Use,
    input  logic                    I_Src2Use,
    input  logic                    I_DestUse,
    input  logic                    I_UsesCC,
    input  logic [NUM_WB-1:0]       I_WbEnable,
    input  logic [NUM_WB*IDX_W-1:0] I_WbRegIdx,
    output logic                    O_DepStall,
    output logic                    O_IssueFire,
    output logic [NUM_REGS-1:0]     O_Pending,
    output logic                    O_Busy,
    output logic                    O_Error
);

    logic [NUM_REGS-1:0] pend, full, nz_nxt, uflow, inc;
    logic active, src1_hz, src2_hz, cc_hz, dest_hz;

    function automatic logic in_range(input logic [IDX_W-1:0] idx);
        return {1'b0, idx} < (IDX_W+1)'(NUM_REGS);
    endfunction

    always_comb begin
        active  = I_LOCK & I_IssueValid & ~I_RESET;
        src1_hz = I_Src1Use && in_range(I_Src1Idx) && pend[I_Src1Idx];
        src2_hz = I_Src2Use && in_range(I_Src2Idx) && pend[I_Src2Idx];
        cc_hz   = 1'b0;
        for (int r = 0; r < CC_REGS && r < NUM_REGS; r++)
            cc_hz = cc_hz | pend[r];
        cc_hz   = cc_hz & I_UsesCC;
        // Counter saturation is the only dest-side hazard; WAW just counts.
        dest_hz = I_DestUse && in_range(I_DestIdx) && full[I_DestIdx];
        O_DepStall  = active & (src1_hz | src2_hz | cc_hz | dest_hz);
        O_IssueFire = active & ~O_DepStall;
        for (int r = 0; r < NUM_REGS; r++)
            inc[r] = O_IssueFire & I_DestUse & (I_DestIdx == IDX_W'(r));
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
        scoreboard_counter #(
            .NUM_WB (NUM_WB),
            .IDX_W  (IDX_W),
            .CNT_W  (CNT_W),
            .REG_ID (g)
        ) u_cnt (
            .I_CLOCK    (I_CLOCK),
            .I_RESET    (I_RESET),
            .I_LOCK     (I_LOCK),
            .I_WbEnable (I_WbEnable),
            .I_WbRegIdx (I_WbRegIdx),
            .inc        (inc[g]),
            .pend_eff   (pend[g]),
            .full       (full[g]),
            .pending    (O_Pending[g]),
            .nz_nxt     (nz_nxt[g]),
            .underflow  (uflow[g])
        );
    end

    always_ff @(posedge I_CLOCK) begin
        if (I_RESET) begin
            O_Busy  <= 1'b0;
            O_Error <= 1'b0;
        end else if (I_LOCK) begin
            O_Busy <= |nz_nxt;
            if (|uflow)
                O_Error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: hazard, bypass, saturation, underflow,
// lock and reset scenarios with hand-computed expectations.
module tb_reg_scoreboard;

    logic        I_CLOCK, I_RESET, I_LOCK, I_IssueValid;
    logic [3:0]  I_Src1Idx, I_Src2Idx, I_DestIdx;
    logic        I_Src1Use, I_Src2Use, I_DestUse, I_UsesCC;
    logic [1:0]  I_WbEnable;
    logic [7:0]  I_WbRegIdx;
    logic        O_DepStall, O_IssueFire, O_Busy, O_Error;
    logic [15:0] O_Pending;

    int n_assert = 0;
    int n_fail   = 0;

    reg_scoreboard dut (
        .I_CLOCK      (I_CLOCK),
        .I_RESET      (I_RESET),
        .I_LOCK       (I_LOCK),
        .I_IssueValid (I_IssueValid),
        .I_Src1Idx    (I_Src1Idx),
        .I_Src2Idx    (I_Src2Idx),
        .I_DestIdx    (I_DestIdx),
        .I_Src1Use    (I_Src1Use),
        .I_Src2Use    (I_Src2Use),
        .I_DestUse    (I_DestUse),
        .I_UsesCC     (I_UsesCC),
        .I_WbEnable   (I_WbEnable),
        .I_WbRegIdx   (I_WbRegIdx),
        .O_DepStall   (O_DepStall),
        .O_IssueFire  (O_IssueFire),
        .O_Pending    (O_Pending),
        .O_Busy       (O_Busy),
        .O_Error      (O_Error)
    );

    initial I_CLOCK = 1'b0;
    always #5 I_CLOCK = ~I_CLOCK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one instruction plus writeback traffic, then let it settle.
    task automatic drv(input logic v, input logic [3:0] s1, input logic u1,
                       input logic [3:0] s2, input logic u2,
                       input logic [3:0] d, input logic ud, input logic cc,
                       input logic [1:0] wen, input logic [3:0] w0, input logic [3:0] w1);
        I_IssueValid = v;
        I_Src1Idx = s1;  I_Src1Use = u1;
        I_Src2Idx = s2;  I_Src2Use = u2;
        I_DestIdx = d;   I_DestUse = ud;
        I_UsesCC  = cc;
        I_WbEnable = wen;
        I_WbRegIdx = {w1, w0};
        #1;
    endtask

    task automatic tick();
        @(posedge I_CLOCK);
        #1;
    endtask

    task automatic idle();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    endtask

    task automatic comb(input string tag, input logic stall, input logic fire);
        chk({tag, "_stall"}, 32'(O_DepStall), 32'(stall));
        chk({tag, "_fire"},  32'(O_IssueFire), 32'(fire));
    endtask

    task automatic regs(input string tag, input logic [15:0] pnd, input logic busy, input logic err);
        chk({tag, "_pending"}, 32'(O_Pending), 32'(pnd));
        chk({tag, "_busy"},    32'(O_Busy),    32'(busy));
        chk({tag, "_error"},   32'(O_Error),   32'(err));
    endtask

    initial begin
        // Reset with an instruction presented: nothing may fire.
        I_RESET = 1'b1;
        I_LOCK  = 1'b1;
        drv(1, 0, 0, 0, 0, 3, 1, 0, 2'b00, 0, 0);
        comb("rst_in", 0, 0);
        tick();
        tick();
        regs("rst_out", 16'h0000, 0, 0);
        I_RESET = 1'b0;

        // R3 dest issue, then RAW on R3.
        drv(1, 0, 0, 0, 0, 3, 1, 0, 2'b00, 0, 0);
        comb("iss_r3", 0, 1);
        tick();
        regs("iss_r3", 16'h0008, 1, 0);
        drv(1, 3, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0);
        comb("raw_r3", 1, 0);
        tick();
        chk("raw_r3_pending", 32'(O_Pending), 32'h0008);

        // Same-cycle writeback bypass releases the RAW.
        drv(1, 3, 1, 0, 0, 0, 0, 0, 2'b01, 3, 0);
        comb("byp_r3", 0, 1);
        tick();
        regs("byp_r3", 16'h0000, 0, 0);

        // Three in-flight writes to R5 without WAW stall, then saturation.
        for (int i = 0; i < 3; i++) begin
            drv(1, 0, 0, 0, 0, 5, 1, 0, 2'b00, 0, 0);
            comb($sformatf("waw_r5_%0d", i), 0, 1);
            tick();
        end
        chk("waw_r5_pending", 32'(O_Pending), 32'h0020);
        drv(1, 0, 0, 0, 0, 5, 1, 0, 2'b00, 0, 0);
        comb("sat_r5", 1, 0);
        drv(1, 0, 0, 0, 0, 5, 1, 0, 2'b10, 0, 5);
        comb("sat_r5_wb", 0, 1);
        tick();
        // Drain: 3 - 2 = 1 still pending, then 1 - 1 = 0 without underflow.
        drv(0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 5, 5);
        tick();
        regs("drain5_a", 16'h0020, 1, 0);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 5, 0);
        tick();
        regs("drain5_b", 16'h0000, 0, 0);

        // R9 twice, double writeback, then an extra writeback underflows.
        drv(1, 0, 0, 0, 0, 9, 1, 0, 2'b00, 0, 0);
        tick();
        tick();
        chk("r9_pending", 32'(O_Pending), 32'h0200);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 9, 9);
        tick();
        regs("r9_dual_wb", 16'h0000, 0, 0);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 0, 9);
        tick();
        regs("r9_uflow", 16'h0000, 0, 1);
        idle();
        tick();
        chk("err_sticky", 32'(O_Error), 32'h1);

        // Condition-code hazard only from registers below CC_REGS.
        drv(1, 0, 0, 0, 0, 2, 1, 0, 2'b00, 0, 0);
        tick();
        drv(1, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0);
        comb("cc_r2", 1, 0);
        drv(1, 0, 0, 0, 0, 12, 1, 0, 2'b01, 2, 0);
        comb("iss_r12", 0, 1);
        tick();
        regs("iss_r12", 16'h1000, 1, 1);
        drv(1, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0);
        comb("cc_r12", 0, 1);
        tick();

        // Lock low: no fire, no stall, state frozen despite writeback.
        I_LOCK = 1'b0;
        drv(1, 12, 1, 0, 0, 12, 1, 0, 2'b01, 12, 0);
        comb("lock_off", 0, 0);
        tick();
        regs("lock_off", 16'h1000, 1, 1);
        I_LOCK = 1'b1;

        // Reset mid-operation discards outstanding writes to R4 and R12.
        drv(1, 0, 0, 0, 0, 4, 1, 0, 2'b00, 0, 0);
        tick();
        tick();
        chk("r4_pending", 32'(O_Pending), 32'h1010);
        I_RESET = 1'b1;
        drv(1, 12, 1, 0, 0, 4, 1, 0, 2'b00, 0, 0);
        comb("mid_rst", 0, 0);
        tick();
        regs("mid_rst", 16'h0000, 0, 0);
        I_RESET = 1'b0;
        drv(1, 4, 1, 12, 1, 0, 0, 1, 2'b00, 0, 0);
        comb("post_rst", 0, 1);
        tick();
        regs("post_rst", 16'h0000, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
